// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write/status bundle for imem_loader.
// The master side is the byte source and the consumer of the memory/CPU controls.
// The slave side is the loader itself.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    modport master (
        output in_valid, in_data,
        input  in_ready, we, waddr, wdata, cpu_hold, load_done, load_err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, we, waddr, wdata, cpu_hold, load_done, load_err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
// Parses a framed byte stream (0xA5, 16-bit LE word count, LE payload words),
// writes one 32-bit word per 4 payload bytes and holds the CPU until loaded.
// Optional feature macro: IMLD_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// state | meaning
// IDLE  | hunting for sync byte 0xA5, other bytes dropped
// LEN0  | waiting for word count low byte
// LEN1  | waiting for word count high byte, range check
// DATA  | assembling payload words, one write per 4th byte
// CSUM  | comparing trailing byte with payload XOR (IMLD_CHECKSUM_EN only)
// DONE  | image loaded, CPU released, 0xA5 restarts a load
// ERR   | frame error, stream blocked until reset
module imem_loader #(
    parameter int IM_SIZE = 1024,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
`ifdef IMLD_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] SYNC = 8'hA5;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [10:0]      idx_q, idx_d;
    logic [1:0]       bidx_q, bidx_d;
    logic [23:0]      asm_q, asm_d;
    logic             we_q, we_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
`ifdef IMLD_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    logic             accept;
    logic [CNT_W-1:0] n_full;
    logic             last_word;

    assign bus.in_ready = ~reset & (state_q != S_ERR);
    assign accept       = bus.in_valid & bus.in_ready;
    assign n_full       = {bus.in_data, cnt_q[7:0]};
    assign last_word    = ({{(CNT_W-11){1'b0}}, idx_q} + CNT_W'(1)) == cnt_q;

    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.cpu_hold  = (state_q != S_DONE);
    assign bus.load_done = (state_q == S_DONE);
    assign bus.load_err  = (state_q == S_ERR);

    // Frame parsing: next state, word assembly and write strobe generation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
`ifdef IMLD_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept && bus.in_data == SYNC) begin
                    state_d = S_LEN0;
                    cnt_d   = '0;
`ifdef IMLD_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            S_LEN0: begin
                if (accept) begin
                    cnt_d[7:0] = bus.in_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    cnt_d  = n_full;
                    idx_d  = '0;
                    bidx_d = '0;
                    if (n_full == '0)
                        state_d = S_DONE;
                    else if (n_full > CNT_W'(IM_SIZE))
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    bidx_d = bidx_q + 2'd1;
                    asm_d  = {bus.in_data, asm_q[23:8]};
`ifdef IMLD_CHECKSUM_EN
                    csum_d = csum_q ^ bus.in_data;
`endif
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = {19'd0, idx_q, 2'b00};
                        wdata_d = {bus.in_data, asm_q};
                        idx_d   = idx_q + 11'd1;
                        if (last_word) begin
`ifdef IMLD_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_DONE;
`endif
                        end
                    end
                end
            end
`ifdef IMLD_CHECKSUM_EN
            S_CSUM: begin
                if (accept)
                    state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            S_ERR: state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            bidx_q  <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
`ifdef IMLD_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef IMLD_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule
